// File: rtl/video_window_align.sv
// video_window_align: measures the raw source geometry, locks onto it and regenerates blanking so a
// centred, offsettable WIDTH x HEIGHT window reaches the rotator. Optional macro: ALIGN_BLACKEN_EN.
module video_window_align #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CW     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [DEPTH-1:0] video_in,
  input  logic             hblank_in,
  input  logic             vblank_in,
  input  logic [4:0]       hoffset,
  input  logic [4:0]       voffset,
  output logic [DEPTH-1:0] video_out,
  output logic             hblank,
  output logic             vblank,
  output logic             locked,
  output logic [CW-1:0]    meas_w,
  output logic [CW-1:0]    meas_h
);

  localparam int unsigned   SW   = CW + 1;
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic {S_UNLOCKED, S_LOCKED} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_hb_d, r_vb_d, r_locked, r_hblank, r_vblank;
  logic [DEPTH-1:0] r_video_out;
  logic [CW-1:0]    r_x, r_y, r_xmax, r_meas_w, r_meas_h, r_hstart, r_vstart;

  logic             w_h_rise, w_v_rise, w_active, w_line, w_geom_eq, w_fits;
  logic             w_x_out, w_y_out, w_hb_nxt, w_vb_nxt;
  logic [DEPTH-1:0] w_video_nxt;
  logic [CW-1:0]    w_x_inc, w_y_inc, w_cand_w, w_cand_h;
  logic [SW-1:0]    w_hend, w_vend;

  // Centred start plus signed offset, clamped to [0, meas-tgt]; 0 when the source is undersized.
  function automatic logic [CW-1:0] win_start(input logic [CW-1:0] meas,
                                              input logic [CW-1:0] tgt,
                                              input logic [4:0]    off);
    logic signed [SW-1:0] span;
    logic signed [SW-1:0] pos;
    logic [CW-1:0]        res;
    span = $signed({1'b0, meas}) - $signed({1'b0, tgt});
    pos  = (span >>> 1) + $signed({{(SW-5){off[4]}}, off});
    if (span[SW-1] || pos[SW-1]) res = '0;
    else if (pos > span)         res = span[CW-1:0];
    else                         res = pos[CW-1:0];
    return res;
  endfunction

  assign w_h_rise = hblank_in & ~r_hb_d;
  assign w_v_rise = vblank_in & ~r_vb_d;
  assign w_active = ~hblank_in & ~vblank_in;
  // A line ending on the same ce as vblank rises still counts toward the frame height.
  assign w_line   = w_h_rise & (~vblank_in | w_v_rise);

  assign w_x_inc  = (r_x == CMAX) ? r_x : r_x + CW'(1);
  assign w_y_inc  = (r_y == CMAX) ? r_y : r_y + CW'(1);
  assign w_cand_w = (r_x > r_xmax) ? r_x : r_xmax;
  assign w_cand_h = w_line ? w_y_inc : r_y;

  // meas_w/meas_h double as the stored geometry the next frame is compared against.
  assign w_geom_eq = (w_cand_w == r_meas_w) && (w_cand_h == r_meas_h);
  assign w_fits    = (w_cand_w >= CW'(WIDTH)) && (w_cand_h >= CW'(HEIGHT));

  assign w_hend  = {1'b0, r_hstart} + SW'(WIDTH);
  assign w_vend  = {1'b0, r_vstart} + SW'(HEIGHT);
  assign w_x_out = (r_x < r_hstart) || ({1'b0, r_x} >= w_hend);
  assign w_y_out = (r_y < r_vstart) || ({1'b0, r_y} >= w_vend);

  always_ff @(posedge clk) begin
    if (reset)   r_state <= S_UNLOCKED;
    else if (ce) r_state <= w_state_nxt;
  end

  // Output mode follows the state held before the vblank edge, so changes land on the next frame.
  always_comb begin
    w_state_nxt = r_state;
    w_video_nxt = video_in;
    w_hb_nxt    = hblank_in;
    w_vb_nxt    = vblank_in;
`ifdef ALIGN_BLACKEN_EN
    w_video_nxt = '0;
    w_hb_nxt    = 1'b1;
    w_vb_nxt    = 1'b1;
`endif
    case (r_state)
      S_UNLOCKED: begin
        if (w_v_rise && w_geom_eq && w_fits) w_state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        w_video_nxt = video_in;
        w_hb_nxt    = hblank_in | w_x_out;
        w_vb_nxt    = vblank_in | w_y_out;
        if (w_v_rise && !w_geom_eq) w_state_nxt = S_UNLOCKED;
      end
      default: w_state_nxt = S_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hb_d      <= 1'b1;
      r_vb_d      <= 1'b1;
      r_x         <= '0;
      r_y         <= '0;
      r_xmax      <= '0;
      r_meas_w    <= '0;
      r_meas_h    <= '0;
      r_hstart    <= '0;
      r_vstart    <= '0;
      r_locked    <= 1'b0;
      r_video_out <= '0;
      r_hblank    <= 1'b1;
      r_vblank    <= 1'b1;
    end else if (ce) begin
      r_hb_d      <= hblank_in;
      r_vb_d      <= vblank_in;
      r_locked    <= (w_state_nxt == S_LOCKED);
      r_video_out <= w_video_nxt;
      r_hblank    <= w_hb_nxt;
      r_vblank    <= w_vb_nxt;
      if (w_h_rise || w_v_rise) r_x <= '0;
      else if (w_active)        r_x <= w_x_inc;
      if (w_v_rise)    r_y <= '0;
      else if (w_line) r_y <= w_y_inc;
      // Frame boundary: publish geometry and re-derive the window with freshly sampled offsets.
      if (w_v_rise) begin
        r_xmax   <= '0;
        r_meas_w <= w_cand_w;
        r_meas_h <= w_cand_h;
        r_hstart <= win_start(w_cand_w, CW'(WIDTH), hoffset);
        r_vstart <= win_start(w_cand_h, CW'(HEIGHT), voffset);
      end else begin
        r_xmax   <= w_cand_w;
      end
    end
  end

  assign video_out = r_video_out;
  assign hblank    = r_hblank;
  assign vblank    = r_vblank;
  assign locked    = r_locked;
  assign meas_w    = r_meas_w;
  assign meas_h    = r_meas_h;

endmodule
